ula_div_unit: RTL

- Multi-cycle signed divide/remainder engine. It is the responder to the control unit's ULAControl codes 0111 (DIV), 1000 (REM), 1001 (DIV by constant) and 1010 (REM by constant).
- It sits beside the single-cycle ULA in the datapath. It accepts an operation with a start pulse, holds busy while iterating, then returns the result with a one-cycle done pulse.
- The datapath stalls the PC and suppresses RegWrite while busy is high.

---
 rtl/ula_div_unit_if.sv | 22 ++
 rtl/ula_div_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ula_div_unit_if.sv
// rtl/ula_div_unit_if.sv - request/response bundle between control unit and divide engine
interface ula_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       ula_control;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, ula_control, a, b,
    input  busy, done, result
  );

  modport slave (
    input  start, ula_control, a, b,
    output busy, done, result
  );
endinterface

// File: rtl/ula_div_unit.sv
// rtl/ula_div_unit.sv - multi-cycle signed divide/remainder engine for ULA codes 0111/1000/1001/1010
module ula_div_unit #(
  parameter int WIDTH         = 32,
  parameter int CONST_DIVISOR = 10
) (
  input logic          clk,
  input logic          rst_n,
  ula_div_unit_if.slave bus
);

  localparam int               CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] CONST_D  = WIDTH'(CONST_DIVISOR);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_CALC, S_FIX, S_DONE} state_t;

  state_t           state;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] d_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] dq_q;
  logic [WIDTH-1:0] dmag_q;
  logic [WIDTH:0]   rem_q;
  logic [CW-1:0]    cnt_q;
  logic             q_neg_q;
  logic             r_neg_q;

  logic             accept;
  logic             const_op;
  logic             is_rem;
  logic             special;
  logic [WIDTH-1:0] special_res;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] d_mag;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

  always_comb begin
    accept      = 1'b0;
    const_op    = 1'b0;
    is_rem      = (op_q == 4'b1000) || (op_q == 4'b1010);
    special     = 1'b0;
    special_res = '0;
    a_mag       = a_q[WIDTH-1] ? -a_q : a_q;
    d_mag       = d_q[WIDTH-1] ? -d_q : d_q;
    rem_shift   = {rem_q[WIDTH-1:0], dq_q[WIDTH-1]};
    trial       = rem_shift - {1'b0, dmag_q};
    q_fix       = q_neg_q ? -dq_q : dq_q;
    r_fix       = WIDTH'(r_neg_q ? -rem_q : rem_q);

    case (bus.ula_control)
      4'b0111, 4'b1000: accept = bus.start;
      4'b1001, 4'b1010: begin
        accept   = bus.start;
        const_op = 1'b1;
      end
      default: accept = 1'b0;
    endcase

    // RISC-V conventions: x/0 gives -1 rem x; MIN/-1 gives MIN rem 0
    if (d_q == '0) begin
      special     = 1'b1;
      special_res = is_rem ? a_q : '1;
    end else if (a_q == MIN_NEG && d_q == '1) begin
      special     = 1'b1;
      special_res = is_rem ? '0 : a_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      a_q      <= '0;
      d_q      <= '0;
      op_q     <= '0;
      dq_q     <= '0;
      dmag_q   <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_q    <= bus.a;
            d_q    <= const_op ? CONST_D : bus.b;
            op_q   <= bus.ula_control;
            busy_q <= 1'b1;
            state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          q_neg_q <= a_q[WIDTH-1] ^ d_q[WIDTH-1];
          r_neg_q <= a_q[WIDTH-1];
          if (special) begin
            result_q <= special_res;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state    <= S_DONE;
          end else begin
            dq_q   <= a_mag;
            dmag_q <= d_mag;
            rem_q  <= '0;
            cnt_q  <= '0;
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          // dq_q shifts dividend bits out the top while quotient bits enter at the bottom
          dq_q  <= {dq_q[WIDTH-2:0], ~trial[WIDTH]};
          rem_q <= trial[WIDTH] ? rem_shift : trial;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          result_q <= is_rem ? r_fix : q_fix;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: begin
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
